// File: rtl/ex_result_buffer.sv
// Two-wide in-order result FIFO between EX output buses and writeback/CDB.
// Optional same-cycle bypass when empty: define EX_RESULT_BYPASS_EN.

module ex_rb_lane #(
  parameter int W = 165
) (
  input  logic         stored_vld,
  input  logic [W-1:0] stored,
  input  logic         byp,
  input  logic         byp_vld,
  input  logic [W-1:0] byp_ent,
  output logic         vld,
  output logic [W-1:0] ent
);
  always_comb begin
    vld = byp ? byp_vld : stored_vld;
    ent = '0;
    if (vld) ent = byp ? byp_ent : stored;
  end
endmodule

module ex_result_buffer #(
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [31:0]                ex_IR_out_1,
  input  logic [31:0]                ex_IR_out_2,
  input  logic [63:0]                ex_NPC_out_1,
  input  logic [63:0]                ex_NPC_out_2,
  input  logic [4:0]                 ex_dest_reg_out_1,
  input  logic [4:0]                 ex_dest_reg_out_2,
  input  logic [63:0]                ex_result_out_1,
  input  logic [63:0]                ex_result_out_2,
  input  logic                       ex_valid_out_1,
  input  logic                       ex_valid_out_2,
  input  logic                       wb_ready,
  output logic [31:0]                wb_IR_1,
  output logic [63:0]                wb_NPC_1,
  output logic [4:0]                 wb_dest_reg_1,
  output logic [63:0]                wb_result_1,
  output logic                       wb_valid_1,
  output logic [31:0]                wb_IR_2,
  output logic [63:0]                wb_NPC_2,
  output logic [4:0]                 wb_dest_reg_2,
  output logic [63:0]                wb_result_2,
  output logic                       wb_valid_2,
  output logic                       stall_ex,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int ENT_W = 32 + 64 + 5 + 64;
  localparam int LANES = 2;

  logic [CW-1:0] cnt_q, cnt_d, after_pop;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [DEPTH-1:0][ENT_W-1:0] mem_q, mem_d;
  logic [1:0] p_cnt, q_cnt;
  logic       byp;

  logic [LANES-1:0][ENT_W-1:0] st_ent, in_ent, out_ent;
  logic [LANES-1:0]            st_vld, in_vld, out_vld;

  // Bus 2 slides into slot 0 when bus 1 is idle, so pushes stay compacted.
  assign in_vld[0] = ex_valid_out_1 | ex_valid_out_2;
  assign in_vld[1] = ex_valid_out_1 & ex_valid_out_2;
  assign in_ent[0] = ex_valid_out_1 ?
    {ex_IR_out_1, ex_NPC_out_1, ex_dest_reg_out_1, ex_result_out_1} :
    {ex_IR_out_2, ex_NPC_out_2, ex_dest_reg_out_2, ex_result_out_2};
  assign in_ent[1] = {ex_IR_out_2, ex_NPC_out_2, ex_dest_reg_out_2, ex_result_out_2};

  assign st_vld[0] = (cnt_q >= CW'(1));
  assign st_vld[1] = (cnt_q >= CW'(2));
  assign st_ent[0] = mem_q[head_q];
  assign st_ent[1] = mem_q[head_q + AW'(1)];

  always_comb begin
    q_cnt = 2'd0;
    if (wb_ready) q_cnt = (cnt_q >= CW'(2)) ? 2'd2 : cnt_q[1:0];
    // Stall from registered count and wb_ready only: no path from ex_valid_*.
    after_pop = cnt_q - CW'(q_cnt);
    stall_ex  = (after_pop > CW'(DEPTH - 2));
`ifdef EX_RESULT_BYPASS_EN
    byp = reset && wb_ready && (cnt_q == '0) && !stall_ex;
`else
    byp = 1'b0;
`endif
    p_cnt = 2'd0;
    if (!stall_ex && !byp) p_cnt = 2'(ex_valid_out_1) + 2'(ex_valid_out_2);
    cnt_d  = cnt_q + CW'(p_cnt) - CW'(q_cnt);
    head_d = head_q + AW'(q_cnt);
    tail_d = tail_q + AW'(p_cnt);
    mem_d  = mem_q;
    if (p_cnt != 2'd0) mem_d[tail_q]          = in_ent[0];
    if (p_cnt == 2'd2) mem_d[tail_q + AW'(1)] = in_ent[1];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Storage is not reset; validity comes solely from the count.
  always_ff @(posedge clock) mem_q <= mem_d;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    ex_rb_lane #(.W(ENT_W)) u_lane (
      .stored_vld (st_vld[l]),
      .stored     (st_ent[l]),
      .byp        (byp),
      .byp_vld    (in_vld[l]),
      .byp_ent    (in_ent[l]),
      .vld        (out_vld[l]),
      .ent        (out_ent[l])
    );
  end

  assign {wb_IR_1, wb_NPC_1, wb_dest_reg_1, wb_result_1} = out_ent[0];
  assign {wb_IR_2, wb_NPC_2, wb_dest_reg_2, wb_result_2} = out_ent[1];
  assign wb_valid_1 = out_vld[0];
  assign wb_valid_2 = out_vld[1];
  assign count      = cnt_q;
endmodule

// File: tb/tb_ex_result_buffer.sv
// Directed self-checking bench for ex_result_buffer (DEPTH = 8).

module tb_ex_result_buffer;
  logic        clock, reset;
  logic [31:0] ex_IR_out_1, ex_IR_out_2;
  logic [63:0] ex_NPC_out_1, ex_NPC_out_2;
  logic [4:0]  ex_dest_reg_out_1, ex_dest_reg_out_2;
  logic [63:0] ex_result_out_1, ex_result_out_2;
  logic        ex_valid_out_1, ex_valid_out_2, wb_ready;
  logic [31:0] wb_IR_1, wb_IR_2;
  logic [63:0] wb_NPC_1, wb_NPC_2;
  logic [4:0]  wb_dest_reg_1, wb_dest_reg_2;
  logic [63:0] wb_result_1, wb_result_2;
  logic        wb_valid_1, wb_valid_2, stall_ex;
  logic [3:0]  count;

  int vectors = 0;
  int errors  = 0;

  ex_result_buffer #(.DEPTH(8)) dut (
    .clock(clock), .reset(reset),
    .ex_IR_out_1(ex_IR_out_1), .ex_IR_out_2(ex_IR_out_2),
    .ex_NPC_out_1(ex_NPC_out_1), .ex_NPC_out_2(ex_NPC_out_2),
    .ex_dest_reg_out_1(ex_dest_reg_out_1), .ex_dest_reg_out_2(ex_dest_reg_out_2),
    .ex_result_out_1(ex_result_out_1), .ex_result_out_2(ex_result_out_2),
    .ex_valid_out_1(ex_valid_out_1), .ex_valid_out_2(ex_valid_out_2),
    .wb_ready(wb_ready),
    .wb_IR_1(wb_IR_1), .wb_NPC_1(wb_NPC_1), .wb_dest_reg_1(wb_dest_reg_1),
    .wb_result_1(wb_result_1), .wb_valid_1(wb_valid_1),
    .wb_IR_2(wb_IR_2), .wb_NPC_2(wb_NPC_2), .wb_dest_reg_2(wb_dest_reg_2),
    .wb_result_2(wb_result_2), .wb_valid_2(wb_valid_2),
    .stall_ex(stall_ex), .count(count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // IR and NPC are tied to the result so they can be predicted by hand.
  task automatic drive(input logic v1, input logic [63:0] r1, input logic [4:0] d1,
                       input logic v2, input logic [63:0] r2, input logic [4:0] d2);
    ex_valid_out_1 = v1; ex_result_out_1 = r1; ex_dest_reg_out_1 = d1;
    ex_IR_out_1 = r1[31:0] ^ 32'hDEAD0000; ex_NPC_out_1 = r1 + 64'd4;
    ex_valid_out_2 = v2; ex_result_out_2 = r2; ex_dest_reg_out_2 = d2;
    ex_IR_out_2 = r2[31:0] ^ 32'hDEAD0000; ex_NPC_out_2 = r2 + 64'd4;
  endtask

  task automatic test_reset();
    reset = 1'b0; wb_ready = 1'b0;
    drive(1'b0, 64'h0, 5'd0, 1'b0, 64'h0, 5'd0);
    #3;
    vectors++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    vectors++; if ({wb_valid_1, wb_valid_2, stall_ex} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {wb_valid_1, wb_valid_2, stall_ex}); end
    vectors++; if (wb_result_1 !== 64'h0) begin errors++; $display("FAIL reset_data got %h want 0", wb_result_1); end
    #4 reset = 1'b1;
    step();
  endtask

  task automatic test_two_push();
    wb_ready = 1'b0;
    drive(1'b1, 64'h11, 5'd5, 1'b1, 64'h22, 5'd6);
    step();
    drive(1'b0, 64'h0, 5'd0, 1'b0, 64'h0, 5'd0);
    vectors++; if (count !== 4'd2) begin errors++; $display("FAIL two_count got %0d want 2", count); end
    vectors++; if ({wb_valid_1, wb_valid_2} !== 2'b11) begin errors++; $display("FAIL two_valid got %b want 11", {wb_valid_1, wb_valid_2}); end
    vectors++; if (wb_result_1 !== 64'h11 || wb_result_2 !== 64'h22) begin errors++; $display("FAIL two_result got %h/%h want 11/22", wb_result_1, wb_result_2); end
    vectors++; if (wb_dest_reg_1 !== 5'd5 || wb_dest_reg_2 !== 5'd6) begin errors++; $display("FAIL two_dest got %0d/%0d want 5/6", wb_dest_reg_1, wb_dest_reg_2); end
    vectors++; if (wb_IR_1 !== 32'hDEAD0011 || wb_NPC_2 !== 64'h26) begin errors++; $display("FAIL two_ir_npc got %h/%h want dead0011/26", wb_IR_1, wb_NPC_2); end
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
    vectors++; if (count !== 4'd0) begin errors++; $display("FAIL two_drain got %0d want 0", count); end
  endtask

  task automatic test_bus2_only();
    wb_ready = 1'b0;
    drive(1'b0, 64'h0, 5'd0, 1'b1, 64'hAB, 5'd7);
    step();
    drive(1'b0, 64'h0, 5'd0, 1'b0, 64'h0, 5'd0);
    vectors++; if (count !== 4'd1) begin errors++; $display("FAIL bus2_count got %0d want 1", count); end
    vectors++; if (wb_valid_1 !== 1'b1 || wb_result_1 !== 64'hAB || wb_dest_reg_1 !== 5'd7) begin errors++; $display("FAIL bus2_lane1 got v=%b r=%h d=%0d want 1/ab/7", wb_valid_1, wb_result_1, wb_dest_reg_1); end
    vectors++; if (wb_valid_2 !== 1'b0 || wb_result_2 !== 64'h0) begin errors++; $display("FAIL bus2_lane2 got v=%b r=%h want 0/0", wb_valid_2, wb_result_2); end
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
  endtask

  // Pointers sit at 3 here, so the fill wraps the storage.
  task automatic test_fill_stall();
    wb_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 64'(2*c+1), 5'd1, 1'b1, 64'(2*c+2), 5'd2);
      step();
      if (c == 2) begin
        vectors++; if (count !== 4'd6 || stall_ex !== 1'b0) begin errors++; $display("FAIL fill6 got cnt=%0d stall=%b want 6/0", count, stall_ex); end
      end
    end
    vectors++; if (count !== 4'd8 || stall_ex !== 1'b1) begin errors++; $display("FAIL fill8 got cnt=%0d stall=%b want 8/1", count, stall_ex); end
    drive(1'b1, 64'd99, 5'd1, 1'b1, 64'd99, 5'd2);
    step();
    vectors++; if (count !== 4'd8 || wb_result_1 !== 64'd1) begin errors++; $display("FAIL full_hold got cnt=%0d r1=%0d want 8/1", count, wb_result_1); end
  endtask

  task automatic test_full_drain();
    wb_ready = 1'b1;
    drive(1'b1, 64'd9, 5'd1, 1'b1, 64'd10, 5'd2);
    #1;
    vectors++; if (stall_ex !== 1'b0) begin errors++; $display("FAIL full_pop_stall got %b want 0", stall_ex); end
    vectors++; if (wb_result_1 !== 64'd1 || wb_result_2 !== 64'd2) begin errors++; $display("FAIL full_pop_data got %0d/%0d want 1/2", wb_result_1, wb_result_2); end
    step();
    drive(1'b0, 64'h0, 5'd0, 1'b0, 64'h0, 5'd0);
    vectors++; if (count !== 4'd8) begin errors++; $display("FAIL full_pushpop_count got %0d want 8", count); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (wb_result_1 !== 64'(3+2*i) || wb_result_2 !== 64'(4+2*i)) begin
        errors++; $display("FAIL drain_order[%0d] got %0d/%0d want %0d/%0d", i, wb_result_1, wb_result_2, 3+2*i, 4+2*i);
      end
      step();
    end
    vectors++; if (count !== 4'd0 || wb_valid_1 !== 1'b0) begin errors++; $display("FAIL drain_empty got cnt=%0d v1=%b want 0/0", count, wb_valid_1); end
    wb_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    wb_ready = 1'b0;
    drive(1'b1, 64'h31, 5'd1, 1'b1, 64'h32, 5'd2); step();
    drive(1'b1, 64'h33, 5'd1, 1'b1, 64'h34, 5'd2); step();
    drive(1'b1, 64'h35, 5'd1, 1'b0, 64'h0, 5'd0);  step();
    vectors++; if (count !== 4'd5) begin errors++; $display("FAIL pre_reset_count got %0d want 5", count); end
    drive(1'b1, 64'h36, 5'd1, 1'b0, 64'h0, 5'd0);
    #2 reset = 1'b0;
    #1;
    vectors++; if (count !== 4'd0 || stall_ex !== 1'b0) begin errors++; $display("FAIL async_reset got cnt=%0d stall=%b want 0/0", count, stall_ex); end
    vectors++; if ({wb_valid_1, wb_valid_2} !== 2'b00 || wb_result_1 !== 64'h0 || wb_IR_2 !== 32'h0) begin errors++; $display("FAIL async_reset_out got v=%b r1=%h want 00/0", {wb_valid_1, wb_valid_2}, wb_result_1); end
    #1 reset = 1'b1;
    drive(1'b1, 64'h41, 5'd9, 1'b0, 64'h0, 5'd0);
    step();
    drive(1'b0, 64'h0, 5'd0, 1'b0, 64'h0, 5'd0);
    vectors++; if (count !== 4'd1 || wb_valid_1 !== 1'b1 || wb_result_1 !== 64'h41 || wb_dest_reg_1 !== 5'd9) begin errors++; $display("FAIL post_reset_push got cnt=%0d v=%b r=%h want 1/1/41", count, wb_valid_1, wb_result_1); end
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
    vectors++; if (count !== 4'd0) begin errors++; $display("FAIL post_reset_drain got %0d want 0", count); end
  endtask

  task automatic test_bypass();
    wb_ready = 1'b1;
    drive(1'b1, 64'h77, 5'd3, 1'b0, 64'h0, 5'd0);
    #1;
`ifdef EX_RESULT_BYPASS_EN
    vectors++; if (wb_valid_1 !== 1'b1 || wb_result_1 !== 64'h77) begin errors++; $display("FAIL bypass_same got v=%b r=%h want 1/77", wb_valid_1, wb_result_1); end
    step();
    drive(1'b0, 64'h0, 5'd0, 1'b0, 64'h0, 5'd0);
    vectors++; if (count !== 4'd0 || wb_valid_1 !== 1'b0) begin errors++; $display("FAIL bypass_next got cnt=%0d v=%b want 0/0", count, wb_valid_1); end
`else
    vectors++; if (wb_valid_1 !== 1'b0 || wb_result_1 !== 64'h0) begin errors++; $display("FAIL nobyp_same got v=%b r=%h want 0/0", wb_valid_1, wb_result_1); end
    step();
    drive(1'b0, 64'h0, 5'd0, 1'b0, 64'h0, 5'd0);
    vectors++; if (count !== 4'd1 || wb_valid_1 !== 1'b1 || wb_result_1 !== 64'h77) begin errors++; $display("FAIL nobyp_next got cnt=%0d v=%b r=%h want 1/1/77", count, wb_valid_1, wb_result_1); end
    step();
`endif
    wb_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_two_push();
    test_bus2_only();
    test_fill_stall();
    test_full_drain();
    test_async_reset();
    test_bypass();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
